// File: rtl/simon_96144_loader_if.sv
// Host/core-facing bundle for the SIMON 96/144 frame loader.
// The master side drives host bytes and core acceptance; the slave side is the loader.
interface simon_96144_loader_if #(
  parameter int N = 48,
  parameter int M = 3
);
  logic [7:0]     byteIn;
  logic           byteValid;
  logic           byteReady;
  logic           newKey;
  logic           newData;
  logic           loadKey;
  logic           loadData;
  logic [M*N-1:0] KEY;
  logic [2*N-1:0] blockIN;
  logic           enc_dec;
  logic           err;

  modport master (
    output byteIn, byteValid, loadKey, loadData,
    input  byteReady, newKey, newData, KEY, blockIN, enc_dec, err
  );

  modport slave (
    input  byteIn, byteValid, loadKey, loadData,
    output byteReady, newKey, newData, KEY, blockIN, enc_dec, err
  );
endinterface

// File: rtl/simon_96144_loader.sv
// Byte-serial frame loader for a SIMON 96/144 core: header byte selects key or data, payload is MSB first.
// Optional idle-byte timeout abort is enabled with `define SIMON_LOADER_TIMEOUT_EN.
module simon_96144_loader #(
  parameter int N  = 48,
  parameter int M  = 3,
  parameter int TO = 255
) (
  input  logic                        clk,
  input  logic                        R,
  simon_96144_loader_if.slave         bus,
  output logic [2:0]                  dbg_state
);
  // Handshake: a byte moves only on a rising edge where byteValid and byteReady are
  // both high; loadKey/loadData are single-edge acceptances honoured only in the matching WAIT state.
  localparam int KEY_W      = M * N;
  localparam int BLK_W      = 2 * N;
  localparam int KEY_BYTES  = KEY_W / 8;
  localparam int DATA_BYTES = BLK_W / 8;
  localparam int CNT_W      = $clog2(KEY_BYTES + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FILL_KEY  = 3'd1,
    FILL_DATA = 3'd2,
    WAIT_KEY  = 3'd3,
    WAIT_DATA = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [BLK_W-1:0]   blk_q, blk_d;
  logic               enc_dec_q, enc_dec_d;
  logic               new_key_q, new_key_d;
  logic               new_data_q, new_data_d;
  logic               xfer;

`ifdef SIMON_LOADER_TIMEOUT_EN
  localparam int TO_W = $clog2(TO + 1);
  logic [TO_W-1:0]    to_q, to_d;
  logic               err_q, err_d;
`endif

  // Ready is forced low while reset is held so no byte can be claimed during R.
  assign bus.byteReady = !R && (state_q == IDLE || state_q == FILL_KEY || state_q == FILL_DATA);
  assign xfer          = bus.byteValid && bus.byteReady;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    key_d     = key_q;
    blk_d     = blk_q;
    enc_dec_d = enc_dec_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          cnt_d = '0;
          if (bus.byteIn[0]) begin
            state_d = FILL_KEY;
          end else begin
            state_d   = FILL_DATA;
            enc_dec_d = bus.byteIn[1];
          end
        end
      end
      FILL_KEY: begin
        if (xfer) begin
          key_d = {key_q[KEY_W-9:0], bus.byteIn};
          if (cnt_q == CNT_W'(KEY_BYTES - 1)) begin
            state_d = WAIT_KEY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      FILL_DATA: begin
        if (xfer) begin
          blk_d = {blk_q[BLK_W-9:0], bus.byteIn};
          if (cnt_q == CNT_W'(DATA_BYTES - 1)) begin
            state_d = WAIT_DATA;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      WAIT_KEY:  if (bus.loadKey)  state_d = IDLE;
      WAIT_DATA: if (bus.loadData) state_d = IDLE;
      default:   state_d = IDLE;
    endcase

`ifdef SIMON_LOADER_TIMEOUT_EN
    // Count consecutive idle cycles while filling; the TO-th one aborts the frame.
    to_d  = '0;
    err_d = 1'b0;
    if ((state_q == FILL_KEY || state_q == FILL_DATA) && !xfer) begin
      if (to_q == TO_W'(TO - 1)) begin
        err_d   = 1'b1;
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        to_d = to_q + TO_W'(1);
      end
    end
`endif

    new_key_d  = (state_d == WAIT_KEY);
    new_data_d = (state_d == WAIT_DATA);
  end

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      key_q      <= '0;
      blk_q      <= '0;
      enc_dec_q  <= 1'b0;
      new_key_q  <= 1'b0;
      new_data_q <= 1'b0;
`ifdef SIMON_LOADER_TIMEOUT_EN
      to_q       <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      key_q      <= key_d;
      blk_q      <= blk_d;
      enc_dec_q  <= enc_dec_d;
      new_key_q  <= new_key_d;
      new_data_q <= new_data_d;
`ifdef SIMON_LOADER_TIMEOUT_EN
      to_q       <= to_d;
      err_q      <= err_d;
`endif
    end
  end

  assign bus.newKey  = new_key_q;
  assign bus.newData = new_data_q;
  assign bus.KEY     = key_q;
  assign bus.blockIN = blk_q;
  assign bus.enc_dec = enc_dec_q;
  assign dbg_state   = state_q;

`ifdef SIMON_LOADER_TIMEOUT_EN
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_simon_96144_loader.sv
// Directed bench for simon_96144_loader: key/data frames, WAIT back-pressure, mid-frame reset, idle stall.
module tb_simon_96144_loader;
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FILL_KEY  = 3'd1;
  localparam logic [2:0] S_WAIT_DATA = 3'd4;

  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;
  int         n_checks;
  int         n_errors;

  simon_96144_loader_if #(.N(48), .M(3)) bus ();

  simon_96144_loader #(.N(48), .M(3), .TO(255)) dut (
    .clk       (clk),
    .R         (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drivers
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.byteIn    = b;
    bus.byteValid = 1'b1;
    while (!bus.byteReady && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check("byte_ready_timeout", 1'b0, 1'b1);
    tick();
    bus.byteValid = 1'b0;
  endtask

  task automatic send_bytes(input logic [143:0] val, input int nb);
    for (int i = 0; i < nb; i++) send_byte(val[8*(nb-1-i) +: 8]);
  endtask

  task automatic send_frame(input logic [7:0] hdr, input logic [143:0] val, input int nb);
    send_byte(hdr);
    send_bytes(val, nb);
  endtask

  task automatic pulse_load_key();
    bus.loadKey = 1'b1;
    tick();
    bus.loadKey = 1'b0;
  endtask

  task automatic pulse_load_data();
    bus.loadData = 1'b1;
    tick();
    bus.loadData = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_key"},     bus.KEY,       '0);
    check({tag, "_blk"},     bus.blockIN,   '0);
    check({tag, "_encdec"},  bus.enc_dec,   1'b0);
    check({tag, "_newkey"},  bus.newKey,    1'b0);
    check({tag, "_newdata"}, bus.newData,   1'b0);
    check({tag, "_err"},     bus.err,       1'b0);
    check({tag, "_ready"},   bus.byteReady, 1'b0);
    check({tag, "_state"},   dbg_state,     S_IDLE);
  endtask

  logic [143:0] key1, key2, data1, data2;
  int           err_pulses;

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    key1          = 144'h1514131211100d0c0b0a0908050403020100;
    key2          = 144'ha1a2a3a4a5a6a7a8a9aaabacadaeafb0b1b2;
    data1         = 144'h2072616c6c69702065687420;
    data2         = 144'h00112233445566778899aabb;
    bus.byteIn    = 8'h00;
    bus.byteValid = 1'b0;
    bus.loadKey   = 1'b0;
    bus.loadData  = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    #1;
    check("ready_after_reset", bus.byteReady, 1'b1);
    tick();

    // Key frame
    send_frame(8'h01, key1, 18);
    check("key_value",   bus.KEY,       key1);
    check("key_newkey",  bus.newKey,    1'b1);
    check("key_ready",   bus.byteReady, 1'b0);
    check("key_newdata", bus.newData,   1'b0);
    pulse_load_key();
    check("key_drop",    bus.newKey,    1'b0);
    check("key_idle",    dbg_state,     S_IDLE);
    check("key_ready2",  bus.byteReady, 1'b1);

    // Data frame, decrypt direction
    send_frame(8'h00, data1, 12);
    check("data_blk",     bus.blockIN, data1);
    check("data_encdec",  bus.enc_dec, 1'b0);
    check("data_newdata", bus.newData, 1'b1);
    check("data_keep_key", bus.KEY,    key1);

    // Back-pressure in WAIT_DATA; stray loadKey is ignored
    bus.byteIn    = 8'haa;
    bus.byteValid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("wait_ready", bus.byteReady, 1'b0);
      tick();
    end
    bus.byteValid = 1'b0;
    pulse_load_key();
    check("wait_state",   dbg_state,     S_WAIT_DATA);
    check("wait_blk",     bus.blockIN,   data1);
    check("wait_newdata", bus.newData,   1'b1);
    check("wait_key",     bus.KEY,       key1);
    pulse_load_data();
    check("data_drop",    bus.newData,   1'b0);
    check("data_idle",    dbg_state,     S_IDLE);

    // Stray loadData in IDLE is ignored
    pulse_load_data();
    check("stray_idle",   dbg_state,     S_IDLE);

    // Reset after 7 of 12 data bytes
    send_frame(8'h00, data2 >> 40, 7);
    rst = 1'b1;
    #1;
    check_all_zero("midreset");
    tick();
    rst = 1'b0;
    tick();
    send_frame(8'h02, data2, 12);
    check("fresh_blk",     bus.blockIN, data2);
    check("fresh_encdec",  bus.enc_dec, 1'b1);
    check("fresh_newdata", bus.newData, 1'b1);
    check("fresh_key",     bus.KEY,     '0);
    pulse_load_data();

    // Idle stall after 5 key bytes
    send_frame(8'h01, key2 >> 104, 5);
    err_pulses = 0;
    for (int i = 0; i < 260; i++) begin
      if (bus.err) err_pulses++;
      tick();
    end
`ifdef SIMON_LOADER_TIMEOUT_EN
    check("to_pulses", err_pulses,  1);
    check("to_state",  dbg_state,   S_IDLE);
    check("to_newkey", bus.newKey,  1'b0);
    check("to_ready",  bus.byteReady, 1'b1);
`else
    check("stall_pulses", err_pulses, 0);
    check("stall_state",  dbg_state,  S_FILL_KEY);
    check("stall_newkey", bus.newKey, 1'b0);
    send_bytes(key2, 13);
    check("stall_key",    bus.KEY,    key2);
    check("stall_newkey2", bus.newKey, 1'b1);
    pulse_load_key();
    check("stall_idle",   dbg_state,  S_IDLE);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/simon_96144_loader.md
SIMON_96144_LOADER -- requirements
Module: simon_96144_loader

Interface
REQ-001 Parameter N, default 48: cipher word width in bits; block is 2*N bits.
REQ-002 Parameter M, default 3: key words; key is M*N bits.
REQ-003 Parameter TO, default 255: idle-byte timeout in cycles, used only under Configuration.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 R  input  1  reset, asynchronous, active-high.
REQ-006 byteIn  input  8  serial host byte.
REQ-007 byteValid  input  1  byteIn is valid this cycle.
REQ-008 byteReady  output  1  loader accepts byteIn this cycle.
REQ-009 newKey  output  1  KEY is valid and pending for the core.
REQ-010 newData  output  1  blockIN and enc_dec are valid and pending for the core.
REQ-011 loadKey  input  1  core acceptance of KEY.
REQ-012 loadData  input  1  core acceptance of blockIN.
REQ-013 KEY  output  M*N  assembled key, word M-1 most significant.
REQ-014 blockIN  output  2*N  assembled block, word 1 most significant.
REQ-015 enc_dec  output  1  direction latched from the frame header.
REQ-016 err  output  1  one-cycle timeout-abort pulse.

Function
REQ-017 A byte transfers only when byteValid and byteReady are both high on a rising edge.
REQ-018 Each frame is one header byte followed by payload bytes: header bit0 = 1 selects key, 0 selects data; header bit1 sets enc_dec; header bits 7:2 are ignored.
REQ-019 Key payload is (M*N)/8 bytes (18); data payload is (2*N)/8 bytes (12); the first payload byte lands in the most significant byte.
REQ-020 FSM states: IDLE, FILL_KEY, FILL_DATA, WAIT_KEY, WAIT_DATA.
REQ-021 IDLE -> FILL_KEY or FILL_DATA on header transfer, selected by header bit0; the byte counter clears.
REQ-022 FILL_* -> WAIT_* on transfer of the last payload byte; the counter wraps to 0.
REQ-023 In WAIT_KEY, newKey is high; in WAIT_DATA, newData is high; KEY, blockIN and enc_dec hold stable.
REQ-024 WAIT_KEY -> IDLE on the edge where loadKey is high; WAIT_DATA -> IDLE on the edge where loadData is high; newKey/newData drop the next cycle.
REQ-025 byteReady is high in IDLE and FILL_* and low in WAIT_*.
REQ-026 loadKey or loadData arriving while not in the matching WAIT state is ignored.
REQ-027 A data frame does not change KEY, and a key frame does not change blockIN; enc_dec updates only on a data header.
REQ-028 Latency: newKey/newData rise the cycle after the last payload byte transfers.

Reset
REQ-029 While R is high: state IDLE, counter 0, KEY 0, blockIN 0, enc_dec 0, newKey 0, newData 0, err 0, byteReady 0.
REQ-030 R asserted mid-frame or mid-WAIT discards the partial frame; the first header after R falls starts a fresh frame.

Configuration
REQ-031 SIMON_LOADER_TIMEOUT_EN defined: in FILL_*, TO consecutive cycles without a transfer send the FSM to IDLE, pulse err for one cycle, and leave KEY/blockIN holding partial contents with newKey/newData low.
REQ-032 SIMON_LOADER_TIMEOUT_EN undefined: no timeout counter exists, err is constant 0, and FILL_* waits indefinitely.

Verification
REQ-033 Key header 0x01, then bytes 15 14 13 12 11 10 0d 0c 0b 0a 09 08 05 04 03 02 01 00 -> KEY = 0x1514131211100d0c0b0a0908050403020100 and newKey high the next cycle; loadKey pulse -> IDLE, byteReady high.
REQ-034 Data header 0x00, then 20 72 61 6c 6c 69 70 20 65 68 74 20 -> blockIN = 0x2072616c6c69702065687420, enc_dec = 0, newData high; KEY unchanged; loadData -> IDLE.
REQ-035 In WAIT_DATA, hold byteValid high for 10 cycles with loadData low -> byteReady low and no bytes consumed; loadKey pulse ignored.
REQ-036 Assert R after 7 of 12 data bytes -> all outputs 0 immediately; a full new data frame with header 0x02 -> correct blockIN and enc_dec = 1.
REQ-037 With SIMON_LOADER_TIMEOUT_EN and TO=255: stall 255 cycles after 5 key bytes -> err pulses once, state IDLE, newKey low; the build without the macro stays in FILL_KEY with err 0.
